// File: rtl/ifq_pkg.sv
// ----------------------------------------------------------------------------
// ifq_pkg
//   Shared types and constants for the instruction prefetch queue.
//
//   ifq_entry_t  : one buffered fetch result, {pc, instr}.
//   IFQ_NOP      : instruction presented when no entry is valid (addi x0,x0,0).
//   IFQ_PC_STEP  : byte distance between sequential instruction words.
//   ifq_next_pc  : sequential successor of a PC. It wraps modulo 2^32.
// ----------------------------------------------------------------------------
package ifq_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifq_entry_t;

  localparam logic [31:0] IFQ_NOP     = 32'h0000_0013;
  localparam logic [31:0] IFQ_PC_STEP = 32'd4;

  function automatic logic [31:0] ifq_next_pc(input logic [31:0] pc);
    return pc + IFQ_PC_STEP;
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// ----------------------------------------------------------------------------
// ifq_fifo
//   Circular buffer of ifq_entry_t. It uses wrap-around read/write pointers
//   and an explicit occupancy count.
//
//   Ports
//     clk, rst        : clock, asynchronous active-low reset
//     flush           : drop every entry this cycle (wins over push/pop)
//     push, push_data : append an entry; legal when full only together with pop
//     pop             : remove the head; ignored when empty
//     head            : oldest entry. It is meaningful only while !empty.
//     count           : occupancy, 0..DEPTH
//     empty           : count == 0
//
//   DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module ifq_fifo
  import ifq_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  ifq_entry_t    push_data,
  input  logic          pop,
  output ifq_entry_t    head,
  output logic [CW-1:0] count,
  output logic          empty
);

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  ifq_entry_t    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  // NOTE: always_comb uses blocking (=) assignments. Every variable gets a
  // default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    // A push into a full buffer is legal only when the head leaves in the
    // same cycle.
    do_push  = push && ((count_q != FULL_COUNT) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: sequential state uses non-blocking (<=) assignments. Every
  // flop then samples the values from before the clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset. count_q alone
  // decides which slots hold valid data, so resetting the array would only
  // add reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/ifetch_prefetch_queue.sv
// ----------------------------------------------------------------------------
// ifetch_prefetch_queue
//   Sits between the instruction-memory port and the fetch stage. It issues
//   sequential word fetches ahead of the pipeline and buffers the returned
//   words with their PCs. Fetch takes them under its stall handshake. An
//   EX-stage redirect flushes the buffer, marks the in-flight responses for
//   discard, and restarts fetching at the target.
//
//   Parameters
//     DEPTH    : buffer entries (power of two, >= 2). It also caps
//                buffered entries plus outstanding requests.
//     RESET_PC : first fetch address after reset.
//
//   Ports
//     clk, rst                  : clock, asynchronous active-low reset
//     redirect_en, redirect_pc  : flush and restart at redirect_pc
//     imem_req, imem_addr       : fetch request and its word address
//     imem_gnt                  : request accepted this cycle
//     imem_rvalid, imem_rdata   : in-order response
//     inst_valid, inst, inst_pc : queue head. inst is NOP and inst_pc is 0
//                                 when nothing is valid.
//     inst_ready                : fetch consumes the head
//
//   Build option
//     IFQ_BYPASS_EN : when the queue is empty and nothing is left to discard,
//                     a response goes straight to inst/inst_pc/inst_valid in
//                     the same cycle. If fetch does not take it, it is
//                     pushed instead.
// ----------------------------------------------------------------------------
module ifetch_prefetch_queue
  import ifq_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int          CW         = $clog2(DEPTH + 1);
  localparam logic [CW:0] CREDIT_MAX = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;

  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  ifq_entry_t    fifo_head;
  ifq_entry_t    fifo_wdata;

  logic credit_ok;
  logic issue;
  logic resp_keep;
  logic bypass_hit;
  logic bypass_take;
  logic fifo_push;
  logic fifo_pop;

  // --------------------------------------------------------------------------
  // Issue and response acceptance
  // --------------------------------------------------------------------------
  always_comb begin
    // Credit rule: every request already issued has a buffer slot reserved.
    // So a response can never arrive to find the buffer full.
    credit_ok = ({1'b0, fifo_count} + {1'b0, outstanding_q}) < CREDIT_MAX;
    // Gating with rst keeps the request low during the reset cycle itself.
    imem_req  = rst && credit_ok && !redirect_en;
    imem_addr = fetch_pc_q;
    issue     = imem_req && imem_gnt;

    // A response belongs to the current stream only when nothing older is
    // still waiting to be discarded.
    resp_keep = rst && imem_rvalid && !redirect_en && (discard_q == '0);

`ifdef IFQ_BYPASS_EN
    bypass_hit = resp_keep && fifo_empty;
`else
    bypass_hit = 1'b0;
`endif
    bypass_take = bypass_hit && inst_ready;

    fifo_push  = resp_keep && !bypass_take;
    fifo_pop   = !fifo_empty && inst_ready && !redirect_en;
    fifo_wdata = '{pc: resp_pc_q, instr: imem_rdata};
  end

  // --------------------------------------------------------------------------
  // Next-state for the fetch pointer, response PC, and in-flight counters
  // --------------------------------------------------------------------------
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;

    if (redirect_en) begin
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      // Every old-stream transaction still pending must be dropped when it
      // returns. That includes a grant the memory gives in this very cycle.
      outstanding_d = outstanding_q + CW'(imem_gnt) - CW'(imem_rvalid);
      discard_d     = outstanding_q + CW'(imem_gnt) - CW'(imem_rvalid);
    end else begin
      if (issue) begin
        fetch_pc_d = ifq_next_pc(fetch_pc_q);
      end
      outstanding_d = outstanding_q + CW'(issue) - CW'(imem_rvalid);
      if (imem_rvalid) begin
        if (discard_q != '0) begin
          discard_d = discard_q - CW'(1);
        end else begin
          resp_pc_d = ifq_next_pc(resp_pc_q);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  // --------------------------------------------------------------------------
  // Buffer
  // --------------------------------------------------------------------------
  ifq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_en),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  // --------------------------------------------------------------------------
  // Fetch-side view. The bypass path only fires while the buffer is empty,
  // so the two sources never compete.
  // --------------------------------------------------------------------------
  always_comb begin
    inst_valid = 1'b0;
    inst       = IFQ_NOP;
    inst_pc    = '0;
    if (bypass_hit) begin
      inst_valid = 1'b1;
      inst       = imem_rdata;
      inst_pc    = resp_pc_q;
    end else if (!fifo_empty) begin
      inst_valid = 1'b1;
      inst       = fifo_head.instr;
      inst_pc    = fifo_head.pc;
    end
  end

endmodule

// File: tb/tb_ifetch_prefetch_queue.sv
// ----------------------------------------------------------------------------
// tb_ifetch_prefetch_queue
//   Bench for ifetch_prefetch_queue with DEPTH=4 and RESET_PC=0.
//   The memory model keeps requests in order and has a configurable latency.
//   The reference model tags each memory transaction with a stream epoch.
//   It drops responses from old epochs, keeps the instruction queue as a
//   plain queue, and derives the request credit from occupancy plus
//   in-flight transactions.
//   Build with IFQ_BYPASS_EN to run against the bypass variant.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ifetch_prefetch_queue;
  import ifq_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;

  always #5 clk = ~clk;

  ifetch_prefetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready)
  );

  // ---------------------------------------------------------------- scoring
  int n_cmp = 0;
  int n_bad = 0;
  int unsigned cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h, want %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  // ------------------------------------------------- memory + reference model
  typedef struct {
    logic [31:0] addr;   // address the DUT actually requested
    logic [31:0] pc;     // address the model expected to be requested
    int unsigned epoch;
    int unsigned due;
  } txn_t;

  txn_t        imem_q[$];
  ifq_entry_t  ref_q[$];
  logic [31:0] ref_addr = RESET_PC;
  int unsigned ref_epoch = 0;
  int unsigned last_due = 0;
  int unsigned lat_min = 1, lat_max = 1, gnt_pct = 100;

  // DUT outputs sampled in the most recent tick
  logic        o_req, o_valid;
  logic [31:0] o_addr, o_inst, o_pc;

  task automatic drive_mem();
    if (imem_q.size() > 0 && imem_q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(imem_q[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
  endtask

  // One clock cycle. The caller sets redirect_en/redirect_pc/inst_ready
  // just after the falling edge.
  task automatic tick();
    logic        e_req, e_valid, m_byp;
    logic [31:0] e_inst, e_pc;
    logic        s_gnt, s_rvalid, s_ready, s_redir;
    logic [31:0] s_rpc, s_addr;
    txn_t        resp;
    logic        have_resp;
    int unsigned ep_old, lat, due;
    #1;
    imem_gnt = imem_req && ($urandom_range(99) < gnt_pct);
    #1;
    e_req = ((ref_q.size() + imem_q.size()) < DEPTH) && !redirect_en;
    m_byp = BYP && imem_rvalid && (ref_q.size() == 0) &&
            (imem_q[0].epoch == ref_epoch) && !redirect_en;
    e_valid = (ref_q.size() > 0) || m_byp;
    if (ref_q.size() > 0) begin
      e_inst = ref_q[0].instr;
      e_pc   = ref_q[0].pc;
    end else if (m_byp) begin
      e_inst = mem_word(imem_q[0].pc);
      e_pc   = imem_q[0].pc;
    end else begin
      e_inst = IFQ_NOP;
      e_pc   = '0;
    end
    o_req = imem_req; o_addr = imem_addr; o_valid = inst_valid; o_inst = inst; o_pc = inst_pc;
    check("imem_req", 32'(o_req), 32'(e_req));
    if (e_req) check("imem_addr", o_addr, ref_addr);
    check("inst_valid", 32'(o_valid), 32'(e_valid));
    check("inst", o_inst, e_inst);
    if (e_valid) check("inst_pc", o_pc, e_pc);
    s_gnt = imem_gnt; s_rvalid = imem_rvalid; s_ready = inst_ready;
    s_redir = redirect_en; s_rpc = redirect_pc; s_addr = imem_addr;
    @(posedge clk);
    ep_old    = ref_epoch;
    have_resp = 1'b0;
    if (s_rvalid) begin
      resp = imem_q.pop_front();
      have_resp = 1'b1;
    end
    if (s_gnt) begin
      lat = $urandom_range(lat_max, lat_min);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      imem_q.push_back('{addr: s_addr, pc: ref_addr, epoch: ep_old, due: due});
      if (!s_redir) ref_addr = ref_addr + 32'd4;
    end
    if (s_redir) begin
      ref_q.delete();
      ref_epoch = ref_epoch + 1;
      ref_addr  = s_rpc;
    end else begin
      if (s_ready && ref_q.size() > 0) ref_q.delete(0);
      if (have_resp && resp.epoch == ep_old && !(m_byp && s_ready))
        ref_q.push_back('{pc: resp.pc, instr: mem_word(resp.pc)});
    end
    @(negedge clk);
    cyc = cyc + 1;
    drive_mem();
  endtask

  task automatic do_reset(input int unsigned lmin, input int unsigned lmax, input int unsigned gpct);
    rst = 1'b0;
    redirect_en = 1'b0;
    inst_ready  = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    #1;
    check("rst imem_req", 32'(imem_req), 32'd0);
    check("rst inst_valid", 32'(inst_valid), 32'd0);
    check("rst inst", inst, IFQ_NOP);
    check("rst inst_pc", inst_pc, 32'd0);
    imem_q.delete();
    ref_q.delete();
    ref_addr  = RESET_PC;
    ref_epoch = ref_epoch + 1;
    last_due  = 0;
    lat_min = lmin; lat_max = lmax; gnt_pct = gpct;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cyc = 0;
    drive_mem();
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic        ready;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          off, hit;
    logic        found;
    logic [31:0] pcs[$];

    // Stall-then-drain with a 1-cycle memory, DEPTH=4, inst_ready low for 6 cycles
    vecs[0]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
    vecs[1]  = '{1'b0, 1'b1, 32'h04, BYP,  32'h00};
    vecs[2]  = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h00};
    vecs[3]  = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h00};
    vecs[4]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h00};
    vecs[5]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h00};
    vecs[6]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h00};
    vecs[7]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h04};
    vecs[8]  = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h08};
    vecs[9]  = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h0C};
    vecs[10] = '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h10};

    #2;
    // 1) Back-to-back stream, 1-cycle memory, inst_ready always high
    do_reset(1, 1, 100);
    off = BYP ? 1 : 2;
    for (int k = 0; k < 16; k++) begin
      inst_ready = 1'b1;
      tick();
      check("stream req", 32'(o_req), 32'd1);
      check("stream valid", 32'(o_valid), 32'(k >= off));
      if (k >= off) begin
        check("stream pc", o_pc, 32'((k - off) * 4));
        check("stream inst", o_inst, mem_word(32'((k - off) * 4)));
      end
    end

    // 2) Table-driven stall and drain
    do_reset(1, 1, 100);
    for (int i = 0; i < 11; i++) begin
      inst_ready = vecs[i].ready;
      tick();
      check($sformatf("vec%0d req", i), 32'(o_req), 32'(vecs[i].exp_req));
      if (vecs[i].exp_req) check($sformatf("vec%0d addr", i), o_addr, vecs[i].exp_addr);
      check($sformatf("vec%0d valid", i), 32'(o_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) check($sformatf("vec%0d pc", i), o_pc, vecs[i].exp_pc);
    end

    // 3) 3-cycle memory, redirect with 2 requests outstanding
    do_reset(3, 3, 100);
    inst_ready = 1'b1;
    tick(); tick();
    redirect_en = 1'b1; redirect_pc = 32'h0000_0100;
    tick();
    check("redir3 req low", 32'(o_req), 32'd0);
    redirect_en = 1'b0;
    found = 1'b0;
    for (int j = 0; j < 12 && !found; j++) begin
      tick();
      if (o_valid) begin
        found = 1'b1;
        check("redir3 first pc", o_pc, 32'h0000_0100);
        check("redir3 first inst", o_inst, mem_word(32'h0000_0100));
      end
    end
    check("redir3 target seen", 32'(found), 32'd1);

    // 4) Redirect coincident with rvalid while credit is exhausted
    do_reset(1, 1, 100);
    repeat (4) tick();
    redirect_en = 1'b1; redirect_pc = 32'h0000_0200; inst_ready = 1'b1;
    tick();
    redirect_en = 1'b0;
    hit = 0;
    for (int j = 1; j <= 8 && hit == 0; j++) begin
      tick();
      if (j == 1) check("redir4 flushed", 32'(o_valid), 32'd0);
      if (o_valid) begin
        hit = j;
        check("redir4 first pc", o_pc, 32'h0000_0200);
      end
    end
    check("redir4 latency", 32'(hit), BYP ? 32'd2 : 32'd3);

    // 5) Reset in mid-operation with buffered entries and outstanding requests
    do_reset(3, 3, 100);
    repeat (5) tick();
    do_reset(1, 1, 100);
    inst_ready = 1'b1;
    tick();
    check("post-reset req", 32'(o_req), 32'd1);
    check("post-reset addr", o_addr, RESET_PC);
    check("post-reset valid", 32'(o_valid), 32'd0);

    // 6) Fetch address wraps modulo 2^32
    tick();
    redirect_en = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect_en = 1'b0;
    pcs.delete();
    for (int j = 0; j < 8; j++) begin
      tick();
      if (o_valid) pcs.push_back(o_pc);
    end
    check("wrap count", 32'(pcs.size() >= 3), 32'd1);
    if (pcs.size() >= 3) begin
      check("wrap pc0", pcs[0], 32'hFFFF_FFF8);
      check("wrap pc1", pcs[1], 32'hFFFF_FFFC);
      check("wrap pc2", pcs[2], 32'h0000_0000);
    end

    // 7) Random traffic checked against the reference model
    do_reset(1, 4, 70);
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset(1, 3, 60);
      inst_ready  = ($urandom_range(99) < 75);
      redirect_en = ($urandom_range(99) < 4);
      redirect_pc = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
      tick();
    end
    redirect_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
